or1200_rfram_generic: RTL and testbench

OR1200_RFRAM_GENERIC -- requirements
Module: or1200_rfram_generic

---
 rtl/or1200_rfram_generic.sv | 85 ++++++++
 tb/tb_or1200_rfram_generic.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_rfram_generic.sv
// ---------------------------------------------------------------------------
// or1200_rfram_generic
//
// Flip-flop based register file with two independent read ports (A, B) and
// one write port (W). Each read port latches its address on a clock edge
// when its enable is high. The read data is then driven combinationally from
// storage, so a write to the latched location shows up right after the
// write edge. Register 0 is hardwired to read as zero. Writes to it are
// accepted and dropped.
//
// Ports:
//   clk     - single clock, all state changes on the rising edge
//   rst     - synchronous active-high reset; clears storage and both
//             latched read addresses
//   ce_a    - read port A enable, latches addr_a
//   addr_a  - read port A address
//   do_a    - read port A data
//   ce_b    - read port B enable, latches addr_b
//   addr_b  - read port B address
//   do_b    - read port B data
//   ce_w    - write port enable
//   we_w    - write strobe; a write happens only when ce_w and we_w are 1
//   addr_w  - write address
//   di_w    - write data
// ---------------------------------------------------------------------------
module or1200_rfram_generic #(
   parameter int dw = 32,
   parameter int aw = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce_a,
   input  logic [aw-1:0] addr_a,
   output logic [dw-1:0] do_a,
   input  logic          ce_b,
   input  logic [aw-1:0] addr_b,
   output logic [dw-1:0] do_b,
   input  logic          ce_w,
   input  logic          we_w,
   input  logic [aw-1:0] addr_w,
   input  logic [dw-1:0] di_w
);

   localparam int NREGS = 1 << aw;

   logic [dw-1:0] mem [NREGS];
   logic [aw-1:0] addr_a_q;
   logic [aw-1:0] addr_b_q;

   // Storage array. Reset wins over a write on the same edge.
   // Location 0 is never written, so after reset it stays zero. Both read
   // ports can then index the array directly without a special zero mux.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (ce_w && we_w && (addr_w != '0)) begin
         mem[addr_w] <= di_w;
      end
   end

   // Latched read addresses. Each one holds its value while its enable
   // is low, so the output keeps tracking the same location.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_a_q <= '0;
         addr_b_q <= '0;
      end else begin
         if (ce_a) begin
            addr_a_q <= addr_a;
         end
         if (ce_b) begin
            addr_b_q <= addr_b;
         end
      end
   end

   // Read data comes straight from storage. Because of this, a write
   // to a latched location is visible right after its edge. This also
   // holds when the address is latched on that same edge.
   assign do_a = mem[addr_a_q];
   assign do_b = mem[addr_b_q];

endmodule

// File: tb/tb_or1200_rfram_generic.sv
// ---------------------------------------------------------------------------
// tb_or1200_rfram_generic
//
// Self-checking bench for or1200_rfram_generic. The reference model is a
// plain array of register contents plus the two addresses last selected on
// each read port. The expected read data is the selected array entry, or
// zero for address 0.
// ---------------------------------------------------------------------------
module tb_or1200_rfram_generic;

   logic        clk;
   logic        rst;
   logic        ce_a;
   logic [4:0]  addr_a;
   logic [31:0] do_a;
   logic        ce_b;
   logic [4:0]  addr_b;
   logic [31:0] do_b;
   logic        ce_w;
   logic        we_w;
   logic [4:0]  addr_w;
   logic [31:0] di_w;

   int passCount = 0;
   int checkCount = 0;

   // Reference model state
   logic [31:0] model [32];
   logic [4:0]  selA;
   logic [4:0]  selB;

   or1200_rfram_generic #(.dw(32), .aw(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .ce_a   (ce_a),
      .addr_a (addr_a),
      .do_a   (do_a),
      .ce_b   (ce_b),
      .addr_b (addr_b),
      .do_b   (do_b),
      .ce_w   (ce_w),
      .we_w   (we_w),
      .addr_w (addr_w),
      .di_w   (di_w)
   );

   // Free-running clock with a 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] expectA();
      return (selA == 5'd0) ? 32'h0 : model[selA];
   endfunction

   function automatic logic [31:0] expectB();
      return (selB == 5'd0) ? 32'h0 : model[selB];
   endfunction

   // Drives one cycle of inputs at the falling edge and waits for the
   // rising edge. It then applies the same cycle to the model and returns
   // 1 ns later, so outputs can be sampled away from the edge.
   task automatic step(input logic r, input logic cea, input logic [4:0] aa,
                       input logic ceb, input logic [4:0] ab,
                       input logic cew, input logic wew, input logic [4:0] aw_,
                       input logic [31:0] d);
      @(negedge clk);
      rst = r; ce_a = cea; addr_a = aa; ce_b = ceb; addr_b = ab;
      ce_w = cew; we_w = wew; addr_w = aw_; di_w = d;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         selA = 5'd0;
         selB = 5'd0;
      end else begin
         if (cew && wew && aw_ != 5'd0) model[aw_] = d;
         if (cea) selA = aa;
         if (ceb) selB = ab;
      end
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, a, d);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkCount++;
      if (do_a !== 32'h0 || do_b !== 32'h0)
         $display("[TB] FAIL reset_out: do_a=%h do_b=%h expected 0", do_a, do_b);
      else passCount++;
      step(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 32'h0);
      checkCount++;
      if (do_a !== 32'h0 || do_b !== 32'h0)
         $display("[TB] FAIL reset_read5: do_a=%h do_b=%h expected 0", do_a, do_b);
      else passCount++;
   endtask

   task automatic test_write_read();
      write(5'd3, 32'hDEADBEEF);
      step(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkCount++;
      if (do_a !== 32'hDEADBEEF)
         $display("[TB] FAIL read_a3: got %h expected DEADBEEF", do_a);
      else passCount++;
      step(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0);
      checkCount++;
      if (do_b !== 32'hDEADBEEF)
         $display("[TB] FAIL read_b3: got %h expected DEADBEEF", do_b);
      else passCount++;
   endtask

   task automatic test_addr_zero();
      write(5'd0, 32'h12345678);
      step(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkCount++;
      if (do_a !== 32'h0 || do_b !== 32'h0)
         $display("[TB] FAIL addr_zero: do_a=%h do_b=%h expected 0", do_a, do_b);
      else passCount++;
   endtask

   task automatic test_hold_writethrough();
      write(5'd7, 32'h11112222);
      write(5'd9, 32'h33334444);
      step(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      step(1'b0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkCount++;
      if (do_a !== 32'h11112222)
         $display("[TB] FAIL hold_a: got %h expected 11112222", do_a);
      else passCount++;
      step(1'b0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'hA5A5A5A5);
      checkCount++;
      if (do_a !== 32'hA5A5A5A5)
         $display("[TB] FAIL writethrough_a: got %h expected A5A5A5A5", do_a);
      else passCount++;
      // Port B latches 7 on the same edge that writes it
      step(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 32'h5A5A5A5A);
      checkCount++;
      if (do_b !== 32'h5A5A5A5A || do_a !== 32'h5A5A5A5A)
         $display("[TB] FAIL same_edge: do_a=%h do_b=%h expected 5A5A5A5A", do_a, do_b);
      else passCount++;
   endtask

   task automatic test_no_write();
      write(5'd4, 32'h0BADF00D);
      step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd4, 32'hFFFFFFFF);
      step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 32'hFFFFFFFF);
      step(1'b0, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 32'h0);
      checkCount++;
      if (do_a !== 32'h0BADF00D || do_b !== 32'h0BADF00D)
         $display("[TB] FAIL no_write: do_a=%h do_b=%h expected 0BADF00D", do_a, do_b);
      else passCount++;
   endtask

   task automatic test_reset_mid();
      int errs;
      for (int i = 1; i < 32; i++) write(5'(i), 32'h100 + i);
      // Reset coinciding with a write and address latches: reset must win
      step(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd5, 32'hCAFEF00D);
      errs = 0;
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b1, 5'(i), 1'b1, 5'(31 - i), 1'b0, 1'b0, 5'd0, 32'h0);
         if (do_a !== 32'h0 || do_b !== 32'h0) begin
            errs++;
            $display("[TB] FAIL reset_mid_clear: addr %0d do_a=%h do_b=%h expected 0",
                     i, do_a, do_b);
         end
      end
      checkCount++;
      if (errs == 0) passCount++;
      write(5'd1, 32'h00000001);
      step(1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 32'h0);
      checkCount++;
      if (do_a !== 32'h1 || do_b !== 32'h1)
         $display("[TB] FAIL post_reset_write: do_a=%h do_b=%h expected 00000001", do_a, do_b);
      else passCount++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0),
              1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom), $urandom);
         if (do_a !== expectA() || do_b !== expectB()) begin
            errs++;
            if (errs <= 5)
               $display("[TB] FAIL random_cycle %0d: do_a=%h exp %h do_b=%h exp %h",
                        n, do_a, expectA(), do_b, expectB());
         end
      end
      checkCount++;
      if (errs == 0) passCount++;
   endtask

   initial begin
      rst = 1'b1; ce_a = 1'b0; addr_a = '0; ce_b = 1'b0; addr_b = '0;
      ce_w = 1'b0; we_w = 1'b0; addr_w = '0; di_w = '0;
      selA = '0; selB = '0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      test_reset();
      test_write_read();
      test_addr_zero();
      test_hold_writethrough();
      test_no_write();
      test_reset_mid();
      test_random();
      idle();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
